// File: rtl/fpu_result_queue.sv
// Result FIFO between the single-precision adder and FPU register-file writeback.
// Buffers result/tag/overflow entries and tracks sticky overflow and NaN status.
module fpu_result_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             in_overflow,
    input  logic [TAG_W-1:0] in_tag,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_overflow,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             ovf_sticky,
    output logic             nan_sticky,
    input  logic             clear_status
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      data_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic             ovf_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;
    logic             in_is_nan;

    // in_ready looks only at occupancy, so a full queue never accepts on a same-cycle pop.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign in_is_nan = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);

    assign out_data     = data_mem[rd_ptr];
    assign out_tag      = tag_mem[rd_ptr];
    assign out_overflow = ovf_mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                tag_mem[i]  <= '0;
                ovf_mem[i]  <= 1'b0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= in_data;
            tag_mem[wr_ptr]  <= in_tag;
            ovf_mem[wr_ptr]  <= in_overflow;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // A set on the same edge as clear_status wins, so no status event is lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_sticky <= 1'b0;
            nan_sticky <= 1'b0;
        end else begin
            if (push && in_overflow) ovf_sticky <= 1'b1;
            else if (clear_status)   ovf_sticky <= 1'b0;
            if (push && in_is_nan)   nan_sticky <= 1'b1;
            else if (clear_status)   nan_sticky <= 1'b0;
        end
    end

endmodule

// File: doc/fpu_result_queue.md
Name: fpu_result_queue

Overview:
- Downstream stage of the single-precision adder. Captures each fadd result word, overflow flag and destination tag into a small FIFO.
- Presents queued results to FPU register-file writeback over a valid/ready handshake.
- Keeps sticky overflow and NaN status bits for the FPU status register.
- Decouples the combinational adder from writeback stalls.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- TAG_W, 5, width of destination register tag.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  adder result valid this cycle.
- in_data  input  32  fadd result d (IEEE-754 single).
- in_overflow  input  1  fadd overflow flag.
- in_tag  input  TAG_W  destination register tag of the issuing instruction.
- in_ready  output  1  queue can accept an entry.
- out_valid  output  1  head entry valid.
- out_data  output  32  head result.
- out_tag  output  TAG_W  head tag.
- out_overflow  output  1  head entry overflow flag.
- out_ready  input  1  writeback consumes the head this cycle.
- count  output  CNT_W  current occupancy.
- ovf_sticky  output  1  sticky: any accepted entry had overflow.
- nan_sticky  output  1  sticky: any accepted entry was NaN.
- clear_status  input  1  clears both sticky bits.

Behaviour:
- Reset (rstn=0, asynchronous):
  - Read pointer, write pointer and count go to 0.
  - All storage entries go to 0.
  - out_valid=0, in_ready=1, ovf_sticky=0, nan_sticky=0.
  - Reset mid-operation discards all queued entries.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are evaluated on the same edge.
- Handshake outputs:
  - in_ready = (count != DEPTH), combinational from count only; no dependence on out_ready, so a full queue never bypasses.
  - out_valid = (count != 0).
  - out_data, out_tag and out_overflow are the storage entry at the read pointer. They are don't-care when out_valid=0; the bench must not check them then.
- Latency:
  - A push at edge N makes the entry visible at the head after edge N when the queue was empty.
  - No combinational path from in_* to out_*.
- Pointers:
  - Each pointer is log2(DEPTH) bits.
  - The write pointer increments on push; the read pointer increments on pop.
  - Both wrap naturally from DEPTH-1 to 0.
- Count update:
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - push & pop: count unchanged, both pointers advance. This is legal only when 0 < count < DEPTH, which the handshake guarantees.
- Ordering: strict FIFO; entries leave in acceptance order.
- Stalls:
  - in_valid while full is ignored.
  - The upstream must hold in_* until in_ready.
  - The queue holds the head stable while out_valid & ~out_ready.
- NaN detect on the accepted word: in_data[30:23]==8'hFF and in_data[22:0]!=0. Infinity (mantissa 0) does not set nan_sticky.
- Sticky bits:
  - ovf_sticky is set on a push with in_overflow=1.
  - nan_sticky is set on a push of a NaN word.
  - clear_status=1 clears both at the edge.
  - Simultaneous clear and set in the same cycle: set wins, so the bit is 1 after the edge.
  - Sticky bits are unaffected by pops.

Test Plan:
- Reset, then check outputs: count=0, out_valid=0, in_ready=1, sticky bits 0.
- Single entry:
  - Stimulus: push in_data=32'h40400000 (3.0), tag=5'd7, out_ready=0.
  - Required: next cycle out_valid=1, out_data=32'h40400000, out_tag=7, count=1.
  - Then assert out_ready for one cycle: count=0, out_valid=0.
- Fill and order:
  - Stimulus: push 5 words 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000 with out_ready=0.
  - Required: the first 4 are accepted and in_ready=0 at count=4. The 5th is not accepted while in_ready=0; upstream holds it until the first pop.
  - Drain in order 1.0, 2.0, 3.0, 4.0, then 5.0.
- Simultaneous push/pop:
  - Stimulus: at count=2, push 32'hC0000000 while popping.
  - Required: count stays 2, head advances, and the new entry drains third.
  - Repeat across pointer wrap, 10 cycles, no loss or reorder.
- Sticky flags:
  - Push 32'h7F800000 with in_overflow=1 -> ovf_sticky=1, nan_sticky=0.
  - Push 32'h7FC00000 -> nan_sticky=1.
  - clear_status in the same cycle as a push of 32'h7FC00001 -> nan_sticky stays 1.
  - clear_status alone -> both 0.
- Async reset mid-operation: with count=3, drop rstn between edges -> immediately out_valid=0, count=0, sticky bits 0, in_ready=1.
